// File: rtl/uart_cmd_decoder.sv
// Command-link receive stage: decodes on/off/toggle opcodes into a registered
// output enable, answers each byte with ACK/NACK via uart_tx, and runs a link watchdog.
module uart_cmd_decoder #(
   parameter logic [7:0]  CMD_ON     = 8'h2A,
   parameter logic [7:0]  CMD_OFF    = 8'h93,
   parameter logic [7:0]  CMD_TOGGLE = 8'hC3,
   parameter logic [7:0]  ACK_BYTE   = 8'h6B,
   parameter logic [7:0]  NACK_BYTE  = 8'hE5,
   parameter int unsigned WDT_CYCLES = 48000000,
   parameter int unsigned WDT_W      = 26
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data_received,
   input  logic       rx_done,
   input  logic       parity_error,
   input  logic       tx_busy,
   output logic       start_tx,
   output logic [7:0] data_to_tx,
   output logic       out_enable,
   output logic       cmd_strobe,
   output logic       wdt_expired,
   output logic       overrun,
   output logic [7:0] err_count
);

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_DECODE     = 2'd1,
      ST_REPLY_REQ  = 2'd2,
      ST_REPLY_BUSY = 2'd3
   } state_t;

   localparam logic [WDT_W-1:0] WDT_MAX  = WDT_W'(WDT_CYCLES);
   localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
   localparam logic [WDT_W-1:0] WDT_ONE  = WDT_W'(1);
   localparam logic [WDT_W-1:0] WDT_ZERO = WDT_W'(0);

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      logic [7:0] result;
      if (value == 8'hFF) begin
         result = value;
      end else begin
         result = value + 8'd1;
      end
      return result;
   endfunction

   state_t           state_r;
   logic             buf_full_r;
   logic [7:0]       buf_data_r;
   logic             buf_perr_r;
   logic [WDT_W-1:0] wdt_cnt_r;

   logic             op_valid_s;
   logic             decode_s;
   logic             cmd_ok_s;
   logic             wdt_fire_s;

   // Classify the held byte and derive the per-cycle decode/watchdog events.
   always_comb begin
      op_valid_s = 1'b0;
      if (buf_perr_r) begin
         op_valid_s = 1'b0;
      end else begin
         case (buf_data_r)
            CMD_ON, CMD_OFF, CMD_TOGGLE: op_valid_s = 1'b1;
            default:                     op_valid_s = 1'b0;
         endcase
      end
      decode_s   = (state_r == ST_DECODE);
      cmd_ok_s   = decode_s & op_valid_s;
      wdt_fire_s = (wdt_cnt_r == WDT_LAST);
   end

   // One-entry holding register; the slot frees as DECODE is left, so a byte landing then is kept.
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_full_r <= 1'b0;
         buf_data_r <= 8'h00;
         buf_perr_r <= 1'b0;
         overrun    <= 1'b0;
      end else if (rx_done && (!buf_full_r || decode_s)) begin
         buf_full_r <= 1'b1;
         buf_data_r <= data_received;
         buf_perr_r <= parity_error;
      end else begin
         if (rx_done) begin
            overrun <= 1'b1;
         end
         if (decode_s) begin
            buf_full_r <= 1'b0;
         end
      end
   end

   // Link watchdog: counts idle cycles since the last valid command, saturating.
   always_ff @(posedge clk) begin
      if (reset) begin
         wdt_cnt_r <= WDT_ZERO;
      end else if (cmd_ok_s) begin
         wdt_cnt_r <= WDT_ZERO;
      end else if (wdt_cnt_r != WDT_MAX) begin
         wdt_cnt_r <= wdt_cnt_r + WDT_ONE;
      end
   end

   // Decode/reply FSM with all of its registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         start_tx    <= 1'b0;
         data_to_tx  <= 8'h00;
         out_enable  <= 1'b0;
         cmd_strobe  <= 1'b0;
         wdt_expired <= 1'b0;
         err_count   <= 8'h00;
      end else begin
         cmd_strobe <= 1'b0;
         // A valid command decoded on the firing edge overrides the forced-off.
         if (wdt_fire_s && !cmd_ok_s) begin
            out_enable  <= 1'b0;
            wdt_expired <= 1'b1;
         end
         case (state_r)
            ST_IDLE: begin
               if (buf_full_r) begin
                  state_r <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (op_valid_s) begin
                  case (buf_data_r)
                     CMD_ON:     out_enable <= 1'b1;
                     CMD_OFF:    out_enable <= 1'b0;
                     CMD_TOGGLE: out_enable <= ~out_enable;
                     default:    out_enable <= out_enable;
                  endcase
                  cmd_strobe  <= 1'b1;
                  data_to_tx  <= ACK_BYTE;
                  wdt_expired <= 1'b0;
               end else begin
                  data_to_tx <= NACK_BYTE;
                  err_count  <= sat_inc8(err_count);
               end
               start_tx <= 1'b1;
               state_r  <= ST_REPLY_REQ;
            end
            ST_REPLY_REQ: begin
               if (tx_busy) begin
                  start_tx <= 1'b0;
                  state_r  <= ST_REPLY_BUSY;
               end
            end
            ST_REPLY_BUSY: begin
               if (!tx_busy) begin
                  state_r <= buf_full_r ? ST_DECODE : ST_IDLE;
               end
            end
            default: begin
               start_tx <= 1'b0;
               state_r  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomized bench for uart_cmd_decoder against a transaction-level reference model,
// plus directed scenarios pinned with hand-computed expectations.
module tb_uart_cmd_decoder;

   localparam int         WDT    = 100;
   localparam int         TX_LEN = 4;
   localparam logic [7:0] ON     = 8'h2A;
   localparam logic [7:0] OFF    = 8'h93;
   localparam logic [7:0] TGL    = 8'hC3;
   localparam logic [7:0] ACK    = 8'h6B;
   localparam logic [7:0] NACK   = 8'hE5;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_done = 1'b0;
   logic       parity_error = 1'b0;
   logic [7:0] data_received = 8'h00;
   logic       tx_busy;
   logic       start_tx;
   logic [7:0] data_to_tx;
   logic       out_enable;
   logic       cmd_strobe;
   logic       wdt_expired;
   logic       overrun;
   logic [7:0] err_count;

   int compared = 0;
   int mismatched = 0;
   bit armed = 1'b0;
   bit hold_busy = 1'b0;
   int tx_cnt;

   always #5 clk = ~clk;

   uart_cmd_decoder #(
      .WDT_CYCLES(WDT),
      .WDT_W     (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .data_received(data_received),
      .rx_done      (rx_done),
      .parity_error (parity_error),
      .tx_busy      (tx_busy),
      .start_tx     (start_tx),
      .data_to_tx   (data_to_tx),
      .out_enable   (out_enable),
      .cmd_strobe   (cmd_strobe),
      .wdt_expired  (wdt_expired),
      .overrun      (overrun),
      .err_count    (err_count)
   );

   // uart_tx stand-in: busy for TX_LEN cycles per request, or held busy on demand
   always @(posedge clk) begin
      if (reset) begin
         tx_busy <= 1'b0;
         tx_cnt  <= 0;
      end else if (hold_busy) begin
         tx_busy <= 1'b1;
      end else if (tx_cnt != 0) begin
         tx_cnt <= tx_cnt - 1;
         if (tx_cnt == 1) tx_busy <= 1'b0;
      end else if (start_tx && !tx_busy) begin
         tx_busy <= 1'b1;
         tx_cnt  <= TX_LEN;
      end else begin
         tx_busy <= 1'b0;
      end
   end

   // Reference model: pending byte, reply engine status, and the observable results
   typedef struct packed {
      bit       held;       // a received byte is waiting in the slot
      bit [7:0] held_byte;
      bit       held_bad;   // parity flag of the waiting byte
      bit       judging;    // the waiting byte gets judged on the coming edge
      bit       asking;     // reply request raised towards uart_tx
      bit       sending;    // uart_tx accepted, waiting for it to finish
      bit       oe;
      bit       strobe;
      bit       wdt;
      bit       ovr;
      bit [7:0] reply;
      bit [7:0] errs;
      int       quiet;      // cycles since the last accepted command
   } model_t;

   model_t m = '0;

   function automatic model_t step(model_t s, bit rst, bit rxd, bit [7:0] d, bit pe, bit busy);
      model_t n;
      bit good;
      n = s;
      if (rst) begin
         n = '0;
      end else begin
         good = s.judging && !s.held_bad && (s.held_byte == ON || s.held_byte == OFF || s.held_byte == TGL);
         n.strobe = 1'b0;
         if (s.judging) begin
            if (good) begin
               if (s.held_byte == ON)       n.oe = 1'b1;
               else if (s.held_byte == OFF) n.oe = 1'b0;
               else                         n.oe = !s.oe;
               n.strobe = 1'b1;
               n.reply  = ACK;
               n.wdt    = 1'b0;
            end else begin
               n.reply = NACK;
               n.errs  = (s.errs == 8'd255) ? 8'd255 : s.errs + 8'd1;
            end
         end
         if (good) begin
            n.quiet = 0;
         end else begin
            if (s.quiet == WDT - 1) begin
               n.oe  = 1'b0;
               n.wdt = 1'b1;
            end
            if (s.quiet < WDT) n.quiet = s.quiet + 1;
         end
         if (rxd && (!s.held || s.judging)) begin
            n.held      = 1'b1;
            n.held_byte = d;
            n.held_bad  = pe;
         end else begin
            if (rxd) n.ovr = 1'b1;
            if (s.judging) n.held = 1'b0;
         end
         if (s.judging) begin
            n.judging = 1'b0;
            n.asking  = 1'b1;
         end else if (s.asking) begin
            if (busy) begin
               n.asking  = 1'b0;
               n.sending = 1'b1;
            end
         end else if (s.sending) begin
            if (!busy) begin
               n.sending = 1'b0;
               n.judging = s.held;
            end
         end else begin
            n.judging = s.held;
         end
      end
      return n;
   endfunction

   // Advance the model on the same edge the DUT samples its inputs
   always @(posedge clk) begin
      m <= step(m, reset, rx_done, data_received, parity_error, tx_busy);
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Continuous check of every output against the model, away from the active edge
   always @(negedge clk) begin
      if (armed) begin
         cmp("start_tx",    32'(start_tx),    32'(m.asking));
         cmp("data_to_tx",  32'(data_to_tx),  32'(m.reply));
         cmp("out_enable",  32'(out_enable),  32'(m.oe));
         cmp("cmd_strobe",  32'(cmd_strobe),  32'(m.strobe));
         cmp("wdt_expired", 32'(wdt_expired), 32'(m.wdt));
         cmp("overrun",     32'(overrun),     32'(m.ovr));
         cmp("err_count",   32'(err_count),   32'(m.errs));
      end
   end

   task automatic tick(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic pe);
      rx_done       = 1'b1;
      data_received = b;
      parity_error  = pe;
      @(posedge clk);
      #1;
      rx_done      = 1'b0;
      parity_error = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
   endtask

   int rates [6] = '{20, 60, 2, 0, 8, 40};

   initial begin
      tick(3);
      armed = 1'b1;
      cmp("rst_start_tx", 32'(start_tx), 32'd0);
      cmp("rst_data", 32'(data_to_tx), 32'h00);
      cmp("rst_oe", 32'(out_enable), 32'd0);
      cmp("rst_err", 32'(err_count), 32'd0);
      reset = 1'b0;

      // Single ON: two-edge latency, one strobe, ACK request dropped after busy rises
      tick(2);
      send(ON, 1'b0);
      tick(1);
      cmp("on_latency_oe", 32'(out_enable), 32'd0);
      tick(1);
      cmp("on_oe", 32'(out_enable), 32'd1);
      cmp("model_on_oe", 32'(m.oe), 32'd1);
      cmp("on_strobe", 32'(cmd_strobe), 32'd1);
      cmp("on_start", 32'(start_tx), 32'd1);
      cmp("on_ack", 32'(data_to_tx), 32'(ACK));
      tick(1);
      cmp("on_strobe_drop", 32'(cmd_strobe), 32'd0);
      cmp("on_busy_seen", 32'(tx_busy), 32'd1);
      cmp("on_start_held", 32'(start_tx), 32'd1);
      tick(1);
      cmp("on_start_drop", 32'(start_tx), 32'd0);
      tick(10);

      // OFF then two toggles: 0 -> 1 -> 0
      send(OFF, 1'b0);
      tick(14);
      send(TGL, 1'b0);
      tick(14);
      cmp("tgl1_oe", 32'(out_enable), 32'd1);
      send(TGL, 1'b0);
      tick(14);
      cmp("tgl2_oe", 32'(out_enable), 32'd0);
      cmp("tgl_ack", 32'(data_to_tx), 32'(ACK));
      cmp("tgl_err", 32'(err_count), 32'd0);

      // Bad opcode and parity error, then saturation of the error count
      send(8'h55, 1'b0);
      tick(14);
      send(ON, 1'b1);
      tick(14);
      cmp("bad_err2", 32'(err_count), 32'd2);
      cmp("model_err2", 32'(m.errs), 32'd2);
      cmp("bad_nack", 32'(data_to_tx), 32'(NACK));
      cmp("bad_oe", 32'(out_enable), 32'd0);
      for (int i = 0; i < 298; i++) begin
         send((i % 2 == 0) ? 8'h00 : TGL, (i % 2 == 1));
         tick(10);
      end
      cmp("err_sat", 32'(err_count), 32'd255);

      // Stalled transmitter: first byte decoded, second held, third dropped
      cmp("no_overrun_yet", 32'(overrun), 32'd0);
      hold_busy = 1'b1;
      send(ON, 1'b0);
      tick(4);
      send(OFF, 1'b0);
      tick(4);
      cmp("held_no_overrun", 32'(overrun), 32'd0);
      send(TGL, 1'b0);
      cmp("overrun_set", 32'(overrun), 32'd1);
      cmp("held_oe", 32'(out_enable), 32'd1);
      tick(40);
      hold_busy = 1'b0;
      tick(14);
      cmp("held_byte_applied", 32'(out_enable), 32'd0);
      cmp("held_byte_ack", 32'(data_to_tx), 32'(ACK));
      cmp("held_reply_done", 32'(start_tx), 32'd0);

      // Watchdog fires exactly WDT cycles after the last valid command
      pulse_reset();
      cmp("rst_err_clear", 32'(err_count), 32'd0);
      cmp("rst_overrun_clear", 32'(overrun), 32'd0);
      send(ON, 1'b0);
      tick(101);
      cmp("wdt_before_oe", 32'(out_enable), 32'd1);
      cmp("wdt_before_flag", 32'(wdt_expired), 32'd0);
      tick(1);
      cmp("wdt_fire_oe", 32'(out_enable), 32'd0);
      cmp("wdt_fire_flag", 32'(wdt_expired), 32'd1);
      cmp("model_wdt_flag", 32'(m.wdt), 32'd1);
      send(ON, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick(2);
         cmp("keepalive_oe", 32'(out_enable), 32'd1);
         cmp("keepalive_flag", 32'(wdt_expired), 32'd0);
         tick(87);
         send(ON, 1'b0);
      end
      tick(2);
      cmp("keepalive_final", 32'(wdt_expired), 32'd0);

      // Reset while a reply is being requested
      tick(12);
      send(OFF, 1'b0);
      tick(2);
      cmp("mid_reply_start", 32'(start_tx), 32'd1);
      pulse_reset();
      cmp("mid_reset_start", 32'(start_tx), 32'd0);
      cmp("mid_reset_oe", 32'(out_enable), 32'd0);
      cmp("mid_reset_data", 32'(data_to_tx), 32'h00);
      tick(3);
      send(OFF, 1'b0);
      tick(2);
      cmp("post_reset_start", 32'(start_tx), 32'd1);
      cmp("post_reset_ack", 32'(data_to_tx), 32'(ACK));
      cmp("post_reset_strobe", 32'(cmd_strobe), 32'd1);
      tick(12);

      // Randomized traffic with varying density, stalls and occasional resets
      for (int cyc = 0; cyc < 6000; cyc++) begin
         reset   = ($urandom_range(0, 499) == 0);
         rx_done = ($urandom_range(0, 99) < rates[cyc / 1000]);
         case ($urandom_range(0, 3))
            0:       data_received = ON;
            1:       data_received = OFF;
            2:       data_received = TGL;
            default: data_received = 8'($urandom_range(0, 255));
         endcase
         parity_error = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 99) == 0) hold_busy = !hold_busy;
         tick(1);
      end
      reset     = 1'b0;
      rx_done   = 1'b0;
      hold_busy = 1'b0;
      tick(30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
